// File: rtl/axi_master_ctrl.sv
// axi_master_ctrl: single-outstanding AXI4 master sequencer.
// Takes one arbitrated request at a time, runs either AR/R or AW/W/B, and
// returns a one-cycle response pulse tagged with the requester id.
//
// Optional feature: define YSYX_22040931_AXI_TIMEOUT_EN to enable a
// watchdog that abandons a transaction after TIMEOUT_CYC busy cycles and
// reports it as an error response. Without it the controller waits forever.
//
// Handshake semantics: a transfer happens on a channel in the cycle where
// both its valid and its ready are high at the rising clock edge; a valid,
// once raised, stays high with a stable payload until that transfer.
module axi_master_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  // request side
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic [ID_W-1:0]   req_id_i,
  // response side
  output logic              rsp_valid_o,
  output logic [ID_W-1:0]   rsp_id_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  // AXI read address
  output logic              axi_arvalid_o,
  input  logic              axi_arready_i,
  output logic [ADDR_W-1:0] axi_araddr_o,
  output logic [ID_W-1:0]   axi_arid_o,
  output logic [2:0]        axi_arsize_o,
  output logic [7:0]        axi_arlen_o,
  output logic [1:0]        axi_arburst_o,
  // AXI read data
  input  logic              axi_rvalid_i,
  output logic              axi_rready_o,
  input  logic [DATA_W-1:0] axi_rdata_i,
  input  logic [ID_W-1:0]   axi_rid_i,
  input  logic [1:0]        axi_rresp_i,
  input  logic              axi_rlast_i,
  // AXI write address
  output logic              axi_awvalid_o,
  input  logic              axi_awready_i,
  output logic [ADDR_W-1:0] axi_awaddr_o,
  output logic [ID_W-1:0]   axi_awid_o,
  output logic [2:0]        axi_awsize_o,
  output logic [7:0]        axi_awlen_o,
  output logic [1:0]        axi_awburst_o,
  // AXI write data
  output logic              axi_wvalid_o,
  input  logic              axi_wready_i,
  output logic [DATA_W-1:0] axi_wdata_o,
  output logic [7:0]        axi_wstrb_o,
  output logic              axi_wlast_o,
  // AXI write response
  input  logic              axi_bvalid_i,
  output logic              axi_bready_o,
  input  logic [ID_W-1:0]   axi_bid_i,
  input  logic [1:0]        axi_bresp_i,
  // debug: current FSM state
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic [ID_W-1:0]   id_q;

  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;

  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [5:0]        lane_shift;
  logic [DATA_W-1:0] size_mask;
  logic [7:0]        strb_base;
  logic [DATA_W-1:0] rdata_d;
  logic              aw_pend_d;
  logic              w_pend_d;

`ifdef YSYX_22040931_AXI_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [TMR_W-1:0] timer_q;
`endif

  // Byte-lane alignment of read data, write data and strobes from the latched request.
  always_comb begin
    lane_shift = {addr_q[2:0], 3'b000};
    size_mask  = '1;
    strb_base  = 8'hFF;
    case (size_q)
      2'd0: begin size_mask = DATA_W'(64'h0000_0000_0000_00FF); strb_base = 8'h01; end
      2'd1: begin size_mask = DATA_W'(64'h0000_0000_0000_FFFF); strb_base = 8'h03; end
      2'd2: begin size_mask = DATA_W'(64'h0000_0000_FFFF_FFFF); strb_base = 8'h0F; end
      default: begin size_mask = '1; strb_base = 8'hFF; end
    endcase
    rdata_d   = (axi_rdata_i >> lane_shift) & size_mask;
    // a write channel is still pending if it was valid and did not transfer this cycle
    aw_pend_d = awvalid_q & ~axi_awready_i;
    w_pend_d  = wvalid_q & ~axi_wready_i;
  end

  // Transaction sequencer: accepts a request, drives the AXI channels, emits the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= 2'd0;
      id_q        <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef YSYX_22040931_AXI_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            size_q  <= req_size_i;
            id_q    <= req_id_i;
`ifdef YSYX_22040931_AXI_TIMEOUT_EN
            timer_q <= '0;
`endif
            if (req_wr_i) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (axi_rvalid_i) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= axi_rresp_i[1];
            state_q     <= S_IDLE;
          end
        end
        S_WR: begin
          awvalid_q <= aw_pend_d;
          wvalid_q  <= w_pend_d;
          if (!aw_pend_d && !w_pend_d) begin
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (axi_bvalid_i) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_err_q   <= axi_bresp_i[1];
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef YSYX_22040931_AXI_TIMEOUT_EN
      // Watchdog wins over any handshake in its final cycle; later slave responses
      // find every ready low and are ignored.
      if (state_q != S_IDLE) begin
        if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
          state_q     <= S_IDLE;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
`endif
    end
  end

  // Signals the single-outstanding design never needs (ids, low resp bit, rlast).
  logic unused_inputs;
  assign unused_inputs = ^{axi_rid_i, axi_bid_i, axi_rresp_i[0], axi_bresp_i[0], axi_rlast_i};

  assign req_ready_o   = (state_q == S_IDLE) & ~reset;

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;

  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arid_o    = id_q;
  assign axi_arsize_o  = {1'b0, size_q};
  assign axi_arlen_o   = 8'd0;
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = rready_q;

  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = id_q;
  assign axi_awsize_o  = {1'b0, size_q};
  assign axi_awlen_o   = 8'd0;
  assign axi_awburst_o = 2'b01;

  assign axi_wvalid_o  = wvalid_q;
  assign axi_wdata_o   = wdata_q << lane_shift;
  assign axi_wstrb_o   = strb_base << addr_q[2:0];
  assign axi_wlast_o   = 1'b1;
  assign axi_bready_o  = bready_q;

  assign state_o       = state_q;

endmodule

// File: tb/tb_axi_master_ctrl.sv
// Testbench for axi_master_ctrl: directed AXI scenarios followed by random
// read/write traffic with random slave delays and responses, checked against
// a byte-lane reference model and an expected-response queue.
module tb_axi_master_ctrl;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_size;
  logic [IW-1:0] req_id;
  logic          rsp_valid, rsp_err;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [IW-1:0] arid;
  logic [2:0]    arsize;
  logic [7:0]    arlen;
  logic [1:0]    arburst;
  logic          rvalid, rready, rlast;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [IW-1:0] awid;
  logic [2:0]    awsize;
  logic [7:0]    awlen;
  logic [1:0]    awburst;
  logic          wvalid, wready, wlast;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;
  logic          bvalid, bready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic [2:0]    state_dbg;

  axi_master_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr), .axi_arid_o(arid),
    .axi_arsize_o(arsize), .axi_arlen_o(arlen), .axi_arburst_o(arburst),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata), .axi_rid_i(rid),
    .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awaddr_o(awaddr), .axi_awid_o(awid),
    .axi_awsize_o(awsize), .axi_awlen_o(awlen), .axi_awburst_o(awburst),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb),
    .axi_wlast_o(wlast),
    .axi_bvalid_i(bvalid), .axi_bready_o(bready), .axi_bid_i(bid), .axi_bresp_i(bresp),
    .state_o(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic logic [63:0] model_rdata(input logic [63:0] d, input logic [63:0] a,
                                              input logic [1:0] s);
    int nbytes;
    int off;
    logic [63:0] v;
    nbytes = 1 << s;
    off    = int'(a % 64'd8);
    v      = d >> (8 * off);
    if (nbytes < 8) v = v % (64'd1 << (8 * nbytes));
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input logic [63:0] a, input logic [1:0] s);
    int nbytes;
    int off;
    logic [15:0] m;
    nbytes = 1 << s;
    off    = int'(a % 64'd8);
    m      = ((16'd1 << nbytes) - 16'd1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [63:0] a);
    int off;
    off = int'(a % 64'd8);
    return d << (8 * off);
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [1:0] size, input logic [3:0] id);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_size  = size;
    req_id    = id;
    step();
    // scramble request fields to show the DUT latched them
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_size  = 2'($urandom);
    req_id    = 4'($urandom);
  endtask

  // Read: arready after ar_dly cycles of arvalid, rvalid after r_dly cycles of rready.
  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] data, input int ar_dly, input int r_dly,
                         input logic [1:0] resp);
    exp_q.push_back(model_rdata(data, addr, size));
    issue(1'b0, addr, {$urandom, $urandom}, size, id);
    check("rd_rsp_low_c1", 64'(rsp_valid), 64'd0);
    check("rd_req_ready_busy", 64'(req_ready), 64'd0);
    check("rd_arvalid_c1", 64'(arvalid), 64'd1);
    check("rd_araddr", araddr, addr);
    check("rd_arsize", 64'(arsize), 64'(size));
    check("rd_arlen_burst", 64'({arlen, arburst}), 64'h1);
    check("rd_arid", 64'(arid), 64'(id));
    check("rd_awvalid_low", 64'(awvalid), 64'd0);
    repeat (ar_dly) begin
      step();
      check("rd_arvalid_hold", 64'(arvalid), 64'd1);
      check("rd_araddr_hold", araddr, addr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("rd_arvalid_drop", 64'(arvalid), 64'd0);
    check("rd_rready", 64'(rready), 64'd1);
    repeat (r_dly) begin
      step();
      check("rd_rready_hold", 64'(rready), 64'd1);
      check("rd_rsp_low_wait", 64'(rsp_valid), 64'd0);
    end
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    rid    = id;
    rlast  = 1'b1;
    step();
    rvalid = 1'b0;
    rdata  = {$urandom, $urandom};
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rsp_rdata", rsp_rdata, exp_q.pop_front());
    check("rd_rsp_id", 64'(rsp_id), 64'(id));
    check("rd_rsp_err", 64'(rsp_err), 64'(resp[1]));
    check("rd_rready_drop", 64'(rready), 64'd0);
  endtask

  // Write: awready/wready each after their own delay, bvalid after b_dly cycles of bready.
  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [1:0] size,
                          input logic [63:0] wd, input int aw_dly, input int w_dly,
                          input logic [1:0] resp, input int b_dly);
    int last;
    exp_q.push_back('0);
    issue(1'b1, addr, wd, size, id);
    check("wr_rsp_low_c1", 64'(rsp_valid), 64'd0);
    check("wr_arvalid_low", 64'(arvalid), 64'd0);
    check("wr_awaddr", awaddr, addr);
    check("wr_awsize", 64'(awsize), 64'(size));
    check("wr_awid", 64'(awid), 64'(id));
    check("wr_wstrb", 64'(wstrb), 64'(model_strb(addr, size)));
    check("wr_wdata", wdata, model_wdata(wd, addr));
    check("wr_wlast", 64'(wlast), 64'd1);
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int k = 0; k <= last; k++) begin
      check("wr_awvalid", 64'(awvalid), 64'(k <= aw_dly));
      check("wr_wvalid", 64'(wvalid), 64'(k <= w_dly));
      check("wr_bready_low", 64'(bready), 64'd0);
      if (k <= w_dly) check("wr_wdata_hold", wdata, model_wdata(wd, addr));
      awready = (k == aw_dly);
      wready  = (k == w_dly);
      step();
      awready = 1'b0;
      wready  = 1'b0;
    end
    check("wr_aw_w_done", 64'({awvalid, wvalid}), 64'd0);
    check("wr_bready", 64'(bready), 64'd1);
    repeat (b_dly) begin
      step();
      check("wr_bready_hold", 64'(bready), 64'd1);
    end
    bvalid = 1'b1;
    bresp  = resp;
    bid    = id;
    step();
    bvalid = 1'b0;
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_rsp_rdata", rsp_rdata, exp_q.pop_front());
    check("wr_rsp_id", 64'(rsp_id), 64'(id));
    check("wr_rsp_err", 64'(rsp_err), 64'(resp[1]));
    check("wr_bready_drop", 64'(bready), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    int          nb;
    req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; req_size = '0; req_id = '0;
    arready = 0; rvalid = 0; rdata = '0; rid = '0; rresp = '0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;

    // reset state
    repeat (3) step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    reset = 1'b0;
    #1;

    // minimum-latency read of the upper word
    do_read(4'b0001, 64'h8000_0004, 2'd2, 64'h1122_3344_5566_7788, 0, 0, 2'b00);
    step();
    check("rsp_one_cycle", 64'(rsp_valid), 64'd0);

    // byte store at offset 3
    do_write(4'b0011, 64'h8000_0003, 2'd0, 64'h0000_0000_0000_00AB, 0, 0, 2'b00, 0);
    step();

    // awready at once, wready four cycles later
    do_write(4'b0011, 64'h8000_0010, 2'd3, 64'hDEAD_BEEF_0BAD_F00D, 0, 4, 2'b00, 1);
    step();

    // wready first, awready late, SLVERR
    do_write(4'b0011, 64'h8000_0026, 2'd1, 64'h0000_0000_0000_BEEF, 3, 0, 2'b10, 0);
    step();

    // read error after stalls, then back-to-back requests in the response cycle
    do_read(4'b0011, 64'h8000_0008, 2'd3, 64'hCAFE_F00D_1234_5678, 0, 4, 2'b10);
    do_read(4'b0001, 64'h8000_0001, 2'd0, 64'h0102_0304_0506_0708, 1, 0, 2'b00);
    do_write(4'b0011, 64'h8000_0004, 2'd2, 64'h0000_0000_A5A5_5A5A, 0, 0, 2'b11, 0);
    step();

    // reset asserted while waiting for read data
    issue(1'b0, 64'h8000_0040, '0, 2'd3, 4'b0001);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("rstR_rready_before", 64'(rready), 64'd1);
    reset  = 1'b1;
    rvalid = 1'b1;
    rdata  = 64'h5555_AAAA_5555_AAAA;
    step();
    check("rstR_rready", 64'(rready), 64'd0);
    check("rstR_axi_valids", 64'({arvalid, awvalid, wvalid, bready}), 64'd0);
    check("rstR_no_rsp", 64'(rsp_valid), 64'd0);
    reset  = 1'b0;
    rvalid = 1'b0;
    #1;
    check("rstR_req_ready", 64'(req_ready), 64'd1);
    step();
    check("rstR_no_rsp_late", 64'(rsp_valid), 64'd0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      nb = 1 << sz;
      a  = {$urandom, $urandom};
      a  = (a & ~64'h7) | 64'($urandom_range(0, 8 / nb - 1) * nb);
      if ($urandom_range(0, 1) == 1)
        do_write(($urandom_range(0, 1) == 1) ? 4'b0011 : 4'b0001, a, sz, {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2));
      else
        do_read(($urandom_range(0, 1) == 1) ? 4'b0011 : 4'b0001, a, sz, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) step();
    end
    step();
    check("final_rsp_low", 64'(rsp_valid), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
